ustc_psum_ctrl: RTL and testbench

- Sequencer for the unstructured sparse tensor core partial-sum buffer: M rows x N columns, accumulate-then-drain.
- Walks the buffer column by column and gates upstream accumulate beats into the current column.
- Triggers the buffer's output phase, counts the drained rows, then clears the buffer before the next output tile.
- Sits between the sparse compute array (beat source) and the psum buffer; software-facing side is start/done plus tile configuration.

---
 rtl/ustc_pkg.sv | 24 ++
 rtl/ustc_psum_ctrl_if.sv | 27 ++
 rtl/ustc_tc_counter.sv | 37 +++
 rtl/ustc_psum_ctrl.sv | 138 +++++++++++++
 tb/tb_ustc_psum_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ustc_pkg.sv
// Shared defaults, state encoding and derived constants for the partial-sum
// buffer sequencer.
package ustc_pkg;

  localparam int unsigned M_DEF      = 16;
  localparam int unsigned N_DEF      = 16;
  localparam int unsigned DW_COL_DEF = 4;
  localparam int unsigned DW_CNT_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_NEXT  = 3'd5
  } state_e;

  // The buffer emits one header beat ahead of its M data rows.
  function automatic int unsigned drain_beats(input int unsigned m);
    return m + 1;
  endfunction

endpackage

// File: rtl/ustc_psum_ctrl_if.sv
// Beat/column/phase signals between the sequencer and the psum buffer
// (master = sequencer, slave = array/buffer side).
interface ustc_psum_ctrl_if
  import ustc_pkg::*;
#(
  parameter int unsigned DW_COL = DW_COL_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic              acc_en;
  logic [DW_COL-1:0] col;
  logic              out_en;
  logic              psum_out_valid;
  logic              psum_clr;

  modport master (
    input  in_valid, psum_out_valid,
    output in_ready, acc_en, col, out_en, psum_clr
  );

  modport slave (
    output in_valid, psum_out_valid,
    input  in_ready, acc_en, col, out_en, psum_clr
  );

endinterface

// File: rtl/ustc_tc_counter.sv
// Up-counter with enable, synchronous clear and a programmable terminal value;
// wraps to zero when enabled at terminal count.
module ustc_tc_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] q_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == term_i);
  assign q_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ustc_psum_ctrl.sv
// Partial-sum buffer sequencer: clear, column-by-column accumulate, flush,
// drain, repeated per output tile of a job.
module ustc_psum_ctrl
  import ustc_pkg::*;
#(
  parameter int unsigned M           = M_DEF,
  parameter int unsigned N           = N_DEF,
  parameter int unsigned DW_COL      = DW_COL_DEF,
  parameter int unsigned DW_CNT      = DW_CNT_DEF,
  parameter int unsigned DRAIN_BEATS = drain_beats(M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DW_CNT-1:0] cfg_k_steps,
  input  logic [DW_CNT-1:0] cfg_tiles,
  ustc_psum_ctrl_if.master  bus,
  output logic [DW_CNT-1:0] tile_idx,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [DW_CNT-1:0] k_steps_q, k_steps_d;
  logic [DW_CNT-1:0] tiles_q, tiles_d;
  logic [DW_CNT-1:0] tile_q, tile_d;

  logic              in_ready;
  logic              acc_en;
  logic [DW_CNT-1:0] beat_cnt;
  logic              beat_tc;
  logic [DW_COL-1:0] col_cnt;
  logic              col_tc;
  logic [DW_CNT-1:0] drain_cnt;
  logic              drain_tc;
  logic              unused_cnt_bits;

  assign in_ready = (state_q == ST_ACCUM);
  assign acc_en   = bus.in_valid & in_ready;

  assign bus.in_ready = in_ready;
  assign bus.acc_en   = acc_en;
  assign bus.col      = col_cnt;
  assign bus.out_en   = (state_q == ST_FLUSH);
  assign bus.psum_clr = (state_q == ST_CLEAR);
  assign busy         = (state_q != ST_IDLE);
  assign tile_idx     = tile_q;

  ustc_tc_counter #(.W(DW_CNT)) u_beat (
    .clk    (clk),
    .rst    (rst),
    .en_i   (acc_en),
    .clr_i  (state_q != ST_ACCUM),
    .term_i (k_steps_q - 1'b1),
    .q_o    (beat_cnt),
    .tc_o   (beat_tc)
  );

  // Column is cleared on the way into CLEAR so it already reads 0 there,
  // and is held at N-1 through FLUSH/DRAIN by suppressing the final wrap.
  ustc_tc_counter #(.W(DW_COL)) u_col (
    .clk    (clk),
    .rst    (rst),
    .en_i   (acc_en & beat_tc & ~col_tc),
    .clr_i  ((state_q == ST_IDLE) || (state_q == ST_NEXT)),
    .term_i (DW_COL'(N - 1)),
    .q_o    (col_cnt),
    .tc_o   (col_tc)
  );

  ustc_tc_counter #(.W(DW_CNT)) u_drain (
    .clk    (clk),
    .rst    (rst),
    .en_i   ((state_q == ST_DRAIN) & bus.psum_out_valid),
    .clr_i  (state_q != ST_DRAIN),
    .term_i (DW_CNT'(DRAIN_BEATS - 1)),
    .q_o    (drain_cnt),
    .tc_o   (drain_tc)
  );

  assign unused_cnt_bits = ^{beat_cnt, drain_cnt};

  always_comb begin
    state_d   = state_q;
    k_steps_d = k_steps_q;
    tiles_d   = tiles_q;
    tile_d    = tile_q;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_steps_d = (cfg_k_steps == '0) ? DW_CNT'(1) : cfg_k_steps;
          tiles_d   = cfg_tiles;
          tile_d    = '0;
          state_d   = (cfg_tiles == '0) ? ST_NEXT : ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (acc_en && beat_tc && col_tc) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.psum_out_valid && drain_tc) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (({1'b0, tile_q} + 1'b1) < {1'b0, tiles_q}) begin
          tile_d  = tile_q + 1'b1;
          state_d = ST_CLEAR;
        end else begin
          done    = 1'b1;
          tile_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_steps_q <= '0;
      tiles_q   <= '0;
      tile_q    <= '0;
    end else begin
      state_q   <= state_d;
      k_steps_q <= k_steps_d;
      tiles_q   <= tiles_d;
      tile_q    <= tile_d;
    end
  end

endmodule

// File: tb/tb_ustc_psum_ctrl.sv
// Directed bench for ustc_psum_ctrl with N=4, M=16 (17 drain beats).
module tb_ustc_psum_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_k_steps;
  logic [7:0] cfg_tiles;
  logic [7:0] tile_idx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0, oe_cnt = 0, done_cnt = 0, acc_cnt = 0;

  ustc_psum_ctrl_if #(.DW_COL(4)) bus_if ();

  ustc_psum_ctrl #(.M(16), .N(4), .DW_COL(4), .DW_CNT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_k_steps (cfg_k_steps),
    .cfg_tiles   (cfg_tiles),
    .bus         (bus_if),
    .tile_idx    (tile_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.psum_clr) clr_cnt++;
      if (bus_if.out_en)   oe_cnt++;
      if (done)            done_cnt++;
      if (bus_if.acc_en)   acc_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit into the CLEAR cycle; returns 1 unit into NEXT.
  task automatic run_tile(input int k, input bit toggle, input int exp_tile, input bit poke);
    int beats = 0;
    int guard = 0;
    int cnt = 0;
    int c = 0;
    bit v;
    #1;
    checks++; if (bus_if.psum_clr !== 1'b1) begin errors++; $display("FAIL clear_pulse: got %0b expected 1", bus_if.psum_clr); end
    checks++; if (bus_if.col !== 4'd0) begin errors++; $display("FAIL clear_col: got %0d expected 0", bus_if.col); end
    checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %0b expected 0", bus_if.in_ready); end
    checks++; if (tile_idx !== 8'(exp_tile)) begin errors++; $display("FAIL clear_tile: got %0d expected %0d", tile_idx, exp_tile); end
    step();
    while (beats < 4 * k && guard < 100) begin
      v = toggle ? (guard % 2 == 0) : 1'b1;
      bus_if.in_valid = v;
      if (poke) begin
        start = (guard == 0);
        cfg_k_steps = 8'd3;
        cfg_tiles = 8'd2;
      end
      #1;
      checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL accum_ready: got %0b expected 1", bus_if.in_ready); end
      checks++; if (bus_if.acc_en !== v) begin errors++; $display("FAIL accum_acc_en: got %0b expected %0b", bus_if.acc_en, v); end
      checks++; if (bus_if.col !== 4'(beats / k)) begin errors++; $display("FAIL accum_col: got %0d expected %0d", bus_if.col, beats / k); end
      checks++; if (bus_if.psum_clr !== 1'b0) begin errors++; $display("FAIL accum_clr: got %0b expected 0", bus_if.psum_clr); end
      if (v) beats++;
      guard++;
      step();
    end
    checks++; if (guard >= 100) begin errors++; $display("FAIL accum_budget: got %0d beats expected %0d", beats, 4 * k); end
    bus_if.in_valid = 1'b0;
    start = 1'b0;
    #1;
    checks++; if (bus_if.out_en !== 1'b1) begin errors++; $display("FAIL flush_out_en: got %0b expected 1", bus_if.out_en); end
    checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b expected 0", bus_if.in_ready); end
    checks++; if (bus_if.col !== 4'd3) begin errors++; $display("FAIL flush_col: got %0d expected 3", bus_if.col); end
    step();
    guard = 0;
    while (cnt < 17 && guard < 60) begin
      v = (c % 5 != 2);
      bus_if.psum_out_valid = v;
      #1;
      checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %0b expected 0", bus_if.in_ready); end
      checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL drain_out_en: got %0b expected 0", bus_if.out_en); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL drain_done: got %0b expected 0", done); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy: got %0b expected 1", busy); end
      if (v) cnt++;
      c++;
      guard++;
      step();
    end
    checks++; if (guard >= 60) begin errors++; $display("FAIL drain_budget: got %0d valids expected 17", cnt); end
    bus_if.psum_out_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    cfg_k_steps = '0;
    cfg_tiles = '0;
    bus_if.in_valid = 1'b0;
    bus_if.psum_out_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", bus_if.in_ready); end
    checks++; if (bus_if.psum_clr !== 1'b0) begin errors++; $display("FAIL reset_clr: got %0b expected 0", bus_if.psum_clr); end
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en: got %0b expected 0", bus_if.out_en); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (bus_if.col !== 4'd0) begin errors++; $display("FAIL reset_col: got %0d expected 0", bus_if.col); end
    checks++; if (tile_idx !== 8'd0) begin errors++; $display("FAIL reset_tile: got %0d expected 0", tile_idx); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic(input bit toggle);
    int acc0 = acc_cnt;
    int done0 = done_cnt;
    cfg_k_steps = 8'd2;
    cfg_tiles = 8'd1;
    start = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %0b expected 0", busy); end
    step();
    start = 1'b0;
    run_tile(2, toggle, 0, 1'b0);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %0b expected 1", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_next_busy: got %0b expected 1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %0b expected 0", done); end
    checks++; if (acc_cnt - acc0 !== 8) begin errors++; $display("FAIL basic_beats: got %0d expected 8", acc_cnt - acc0); end
    checks++; if (done_cnt - done0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - done0); end
  endtask

  task automatic test_multi_tile();
    int clr0 = clr_cnt;
    int oe0 = oe_cnt;
    int done0 = done_cnt;
    cfg_k_steps = 8'd1;
    cfg_tiles = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      run_tile(1, 1'b0, t, 1'b0);
      #1;
      checks++; if (done !== (t == 2)) begin errors++; $display("FAIL multi_done_t%0d: got %0b expected %0b", t, done, t == 2); end
      checks++; if (tile_idx !== 8'(t)) begin errors++; $display("FAIL multi_tile_t%0d: got %0d expected %0d", t, tile_idx, t); end
      step();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multi_busy: got %0b expected 0", busy); end
    checks++; if (clr_cnt - clr0 !== 3) begin errors++; $display("FAIL multi_clr_count: got %0d expected 3", clr_cnt - clr0); end
    checks++; if (oe_cnt - oe0 !== 3) begin errors++; $display("FAIL multi_oe_count: got %0d expected 3", oe_cnt - oe0); end
    checks++; if (done_cnt - done0 !== 1) begin errors++; $display("FAIL multi_done_count: got %0d expected 1", done_cnt - done0); end
  endtask

  task automatic test_zero_cfg();
    int clr0 = clr_cnt;
    int oe0 = oe_cnt;
    int acc0;
    cfg_k_steps = 8'd0;
    cfg_tiles = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done: got %0b expected 1", done); end
    checks++; if (bus_if.psum_clr !== 1'b0) begin errors++; $display("FAIL empty_clr: got %0b expected 0", bus_if.psum_clr); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %0b expected 0", busy); end
    checks++; if (clr_cnt - clr0 !== 0 || oe_cnt - oe0 !== 0) begin errors++; $display("FAIL empty_pulses: got clr %0d oe %0d expected 0 0", clr_cnt - clr0, oe_cnt - oe0); end
    acc0 = acc_cnt;
    cfg_tiles = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_tile(1, 1'b0, 0, 1'b0);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL k0_done: got %0b expected 1", done); end
    step();
    checks++; if (acc_cnt - acc0 !== 4) begin errors++; $display("FAIL k0_beats: got %0d expected 4", acc_cnt - acc0); end
  endtask

  task automatic test_start_busy();
    cfg_k_steps = 8'd2;
    cfg_tiles = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_tile(2, 1'b0, 0, 1'b1);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %0b expected 1", done); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    cfg_k_steps = 8'd1;
    cfg_tiles = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_tile(1, 1'b0, 0, 1'b0);
    start = 1'b1;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %0b expected 1", done); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0b expected 0", busy); end
    step();
    start = 1'b0;
    run_tile(1, 1'b0, 0, 1'b0);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %0b expected 1", done); end
    step();
  endtask

  task automatic test_reset_mid();
    cfg_k_steps = 8'd1;
    cfg_tiles = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    bus_if.in_valid = 1'b1;
    repeat (4) step();
    bus_if.in_valid = 1'b0;
    step();
    bus_if.psum_out_valid = 1'b1;
    bus_if.in_valid = 1'b1;
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    checks++; if (bus_if.col !== 4'd0) begin errors++; $display("FAIL rstmid_col: got %0d expected 0", bus_if.col); end
    checks++; if (bus_if.acc_en !== 1'b0) begin errors++; $display("FAIL rstmid_acc_en: got %0b expected 0", bus_if.acc_en); end
    checks++; if (done !== 1'b0 || bus_if.out_en !== 1'b0 || bus_if.psum_clr !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got %0b%0b%0b expected 000", done, bus_if.out_en, bus_if.psum_clr); end
    bus_if.psum_out_valid = 1'b0;
    bus_if.in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %0b expected 0", busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    run_tile(1, 1'b0, 0, 1'b0);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done: got %0b expected 1", done); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_multi_tile();
    test_zero_cfg();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
